// File: rtl/gauss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gauss_pkg
// Purpose  : Shared widths, types and 3x3 binomial kernel weights for the
//            gauss_window_gen slice.
//            PIX_W  - input pixel width
//            SUM_W  - width of each weighted window term
//            C_WEIGHT - per-tap weight, tap k = 3*wr + wc (1,2,1/2,4,2/1,2,1)
// Revision : 1.0 - initial release
// ============================================================================
package gauss_pkg;

    localparam int PIX_W  = 8;
    localparam int SUM_W  = 12;
    localparam int N_TAPS = 9;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [SUM_W-1:0] term_t;

    // Binomial kernel; the weights add up to 16, so nine full-scale terms
    // total 16*255 = 4080, which still fits a 12-bit accumulator.
    localparam logic [N_TAPS-1:0][2:0] C_WEIGHT = {
        3'd1, 3'd2, 3'd1,
        3'd2, 3'd4, 3'd2,
        3'd1, 3'd2, 3'd1
    };

    // Weighted term, zero-extended to SUM_W bits.
    function automatic term_t weigh(input pix_t pix, input logic [2:0] w);
        return term_t'(pix) * term_t'(w);
    endfunction

endpackage : gauss_pkg
`default_nettype wire

// File: rtl/gauss_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : gauss_row_buf
// Purpose  : One image row of pixel storage. Read is combinational at addr,
//            write lands on the rising edge at the same addr, so a read in
//            the write cycle returns the value from the previous row.
//            Contents are intentionally not reset.
// Ports    : clk   - clock
//            we    - write enable
//            addr  - read/write column index
//            wdata - pixel to store
//            rdata - pixel currently stored at addr
// Revision : 1.0 - initial release
// ============================================================================
module gauss_row_buf
    import gauss_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);

    pix_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : gauss_row_buf
`default_nettype wire

// File: rtl/gauss_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : gauss_window_gen
// Purpose  : Builds a 3x3 sliding window over a raster pixel stream and emits
//            the nine Gaussian-weighted terms one cycle after each accepted
//            pixel whose window lies entirely inside the current frame.
// Ports    : clk       - clock
//            rst       - synchronous active-high reset
//            in_valid  - pixel accepted this cycle (no backpressure)
//            in_pix    - raster-order pixel
//            in_sof    - start-of-frame marker (only with GAUSS_SOF_SYNC_EN)
//            win_valid - single-cycle pulse: w_terms holds a new window
//            w_terms   - term k at [SUM_W*k +: SUM_W], k = 3*wr + wc,
//                        wr = 0 oldest row, wc = 0 oldest column
// Config   : `define GAUSS_SOF_SYNC_EN to add in_sof, which forces the pixel
//            it accompanies to be position (0,0).
// Revision : 1.0 - initial release
// ============================================================================
module gauss_window_gen
    import gauss_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
`ifdef GAUSS_SOF_SYNC_EN
    input  logic                 in_sof,
`endif
    input  logic [PIX_W-1:0]     in_pix,
    output logic                 win_valid,
    output logic [9*SUM_W-1:0]   w_terms
);

    localparam int              C_CW       = $clog2(IMG_W);
    localparam int              C_RW       = $clog2(IMG_H);
    localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(IMG_W - 1);
    localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(IMG_H - 1);

    logic [C_CW-1:0]    r_col;
    logic [C_RW-1:0]    r_row;
    logic               r_win_valid;
    logic [9*SUM_W-1:0] r_terms;
    pix_t               r_win [N_TAPS];

    logic               w_sof;
    logic [C_CW-1:0]    w_col;
    logic [C_RW-1:0]    w_row;
    logic               w_qual;
    logic               w_we;
    pix_t               w_lb1_rd;
    pix_t               w_lb2_rd;
    pix_t               w_win_nxt [N_TAPS];
    logic [9*SUM_W-1:0] w_terms_nxt;

`ifdef GAUSS_SOF_SYNC_EN
    assign w_sof = in_sof & in_valid;
`else
    assign w_sof = 1'b0;
`endif

    // A reset cycle discards the pixel, so it must not land in the buffers.
    assign w_we = in_valid & ~rst;

    // lb1 holds the previous row, lb2 the row before; lb2 is refilled from
    // the value lb1 is about to lose.
    gauss_row_buf #(.DEPTH(IMG_W), .AW(C_CW)) u_lb1 (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_col),
        .wdata (in_pix),
        .rdata (w_lb1_rd)
    );

    gauss_row_buf #(.DEPTH(IMG_W), .AW(C_CW)) u_lb2 (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_col),
        .wdata (w_lb1_rd),
        .rdata (w_lb2_rd)
    );

    always_comb begin
        // SOF overrides the counters for the current pixel only; they then
        // advance from (0,0).
        w_col = w_sof ? '0 : r_col;
        w_row = w_sof ? '0 : r_row;

        for (int wr = 0; wr < 3; wr++) begin
            w_win_nxt[3*wr]     = r_win[3*wr + 1];
            w_win_nxt[3*wr + 1] = r_win[3*wr + 2];
        end
        w_win_nxt[2] = w_lb2_rd;
        w_win_nxt[5] = w_lb1_rd;
        w_win_nxt[8] = in_pix;

        w_terms_nxt = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_terms_nxt[k*SUM_W +: SUM_W] = weigh(w_win_nxt[k], C_WEIGHT[k]);
        end
    end

    // Columns 0/1 and rows 0/1 would pull in pixels from the previous row
    // or frame, so only interior positions produce a window.
    assign w_qual = (w_col >= C_CW'(2)) && (w_row >= C_RW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_terms     <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_win_valid <= in_valid & w_qual;
            if (in_valid) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    r_win[k] <= w_win_nxt[k];
                end
                if (w_qual) begin
                    r_terms <= w_terms_nxt;
                end
                if (w_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == C_ROW_LAST) ? '0 : w_row + C_RW'(1);
                end else begin
                    r_col <= w_col + C_CW'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    assign win_valid = r_win_valid;
    assign w_terms   = r_terms;

endmodule : gauss_window_gen
`default_nettype wire

// File: tb/tb_gauss_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_window_gen
// Purpose  : Self-checking bench for gauss_window_gen on a 4x4 image.
//            A frame-image reference model predicts every window from pixel
//            positions; table vectors and directed sequences cover white
//            frame, ramp, bubbles, mid-frame reset, frame wrap and (with
//            GAUSS_SOF_SYNC_EN) SOF resync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         sof = 1'b0;
    logic [7:0]   in_pix = '0;
    logic         win_valid;
    logic [107:0] w_terms;

    gauss_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef GAUSS_SOF_SYNC_EN
        .in_sof    (sof),
`endif
        .in_pix    (in_pix),
        .win_valid (win_valid),
        .w_terms   (w_terms)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           img [H][W];
    int           pos = 0;
    logic         exp_v = 1'b0;
    logic [107:0] exp_t = '0;

    // Per-sequence statistics
    int           acc_cnt;
    int           pulse_cnt;
    int           first_acc;
    logic [107:0] first_terms;
    int           sums [$];
    int           pulse_acc [$];

    typedef struct {
        logic       vld;
        logic [7:0] pix;
        logic       exp_win;
        int         exp_sum;
    } vec_t;

    task automatic chk(input string name, input logic [107:0] got, input logic [107:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int term_sum(input logic [107:0] t);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(t[k*12 +: 12]);
        return s;
    endfunction

    // Separable [1 2 1] x [1 2 1] kernel applied to the stored image.
    function automatic logic [107:0] ref_window(input int r, input int c);
        logic [107:0] t = '0;
        for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
                int w = ((wr == 1) ? 2 : 1) * ((wc == 1) ? 2 : 1);
                t[(3*wr + wc)*12 +: 12] = 12'(img[r-2+wr][c-2+wc] * w);
            end
        end
        return t;
    endfunction

    task automatic clr_stats();
        acc_cnt   = 0;
        pulse_cnt = 0;
        first_acc = -1;
        first_terms = '0;
        sums.delete();
        pulse_acc.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic s, input logic r);
        @(negedge clk);
        rst = r; in_valid = v; in_pix = p; sof = s;
        if (r) begin
            pos = 0; exp_v = 1'b0; exp_t = '0;
        end else if (v) begin
            int rr, cc;
            if (s) pos = 0;
            rr = pos / W;
            cc = pos % W;
            img[rr][cc] = int'(p);
            exp_v = (rr >= 2) && (cc >= 2);
            if (exp_v) exp_t = ref_window(rr, cc);
            pos = (pos + 1) % (W * H);
            acc_cnt++;
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("win_valid", 108'(win_valid), 108'(exp_v));
        chk("w_terms", w_terms, exp_t);
        if (win_valid === 1'b1) begin
            pulse_cnt++;
            sums.push_back(term_sum(w_terms));
            pulse_acc.push_back(acc_cnt);
            if (pulse_cnt == 1) begin
                first_acc   = acc_cnt;
                first_terms = w_terms;
            end
        end
        rst = 1'b0; in_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        clr_stats();
    endtask

    task automatic ramp_frame(input bit bubbles);
        for (int i = 0; i < W*H; i++) begin
            if (bubbles) begin
                int gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
            end
            step(1'b1, 8'(16*(i/W) + (i%W)), 1'b0, 1'b0);
        end
    endtask

    task automatic chk_first_ramp(input string tag);
        chk({tag, "_k0"}, 108'(first_terms[0*12 +: 12]), 108'(0));
        chk({tag, "_k1"}, 108'(first_terms[1*12 +: 12]), 108'(2));
        chk({tag, "_k4"}, 108'(first_terms[4*12 +: 12]), 108'(68));
        chk({tag, "_k8"}, 108'(first_terms[8*12 +: 12]), 108'(34));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [18];
        int   ramp_sums [4];
        int   f1, f2, f2_early;

        tbl = '{
            '{1'b1, 8'h00, 1'b0, 0},   '{1'b1, 8'h01, 1'b0, 0},
            '{1'b1, 8'h02, 1'b0, 0},   '{1'b1, 8'h03, 1'b0, 0},
            '{1'b1, 8'h10, 1'b0, 0},   '{1'b1, 8'h11, 1'b0, 0},
            '{1'b1, 8'h12, 1'b0, 0},   '{1'b1, 8'h13, 1'b0, 0},
            '{1'b1, 8'h20, 1'b0, 0},   '{1'b1, 8'h21, 1'b0, 0},
            '{1'b1, 8'h22, 1'b1, 272}, '{1'b0, 8'h00, 1'b0, 0},
            '{1'b1, 8'h23, 1'b1, 288}, '{1'b1, 8'h30, 1'b0, 0},
            '{1'b1, 8'h31, 1'b0, 0},   '{1'b1, 8'h32, 1'b1, 528},
            '{1'b1, 8'h33, 1'b1, 544}, '{1'b0, 8'h00, 1'b0, 0}
        };
        ramp_sums = '{272, 288, 528, 544};

        // Reset state
        do_reset();
        chk("reset_win_valid", 108'(win_valid), 108'(0));
        chk("reset_terms", w_terms, 108'(0));

        // Constant-white frame
        clr_stats();
        for (int i = 0; i < W*H; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("white_pulses", 108'(pulse_cnt), 108'(4));
        chk("white_first_acc", 108'(first_acc), 108'(11));
        foreach (sums[i]) chk("white_sum", 108'(sums[i]), 108'(4080));

        // Ramp from the vector table, including idle cycles
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].pix, 1'b0, 1'b0);
            chk("tbl_win_valid", 108'(win_valid), 108'(tbl[i].exp_win));
            if (tbl[i].exp_win) chk("tbl_sum", 108'(term_sum(w_terms)), 108'(tbl[i].exp_sum));
        end
        chk_first_ramp("ramp");

        // Ramp with random bubbles
        do_reset();
        ramp_frame(1'b1);
        chk("bubble_pulses", 108'(pulse_cnt), 108'(4));
        for (int i = 0; i < 4 && i < sums.size(); i++)
            chk("bubble_sum", 108'(sums[i]), 108'(ramp_sums[i]));

        // Reset mid-frame, with a valid pixel colliding with reset
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        clr_stats();
        ramp_frame(1'b0);
        chk("midrst_first_acc", 108'(first_acc), 108'(11));
        chk("midrst_pulses", 108'(pulse_cnt), 108'(4));
        chk_first_ramp("midrst");

        // Two back-to-back frames
        do_reset();
        ramp_frame(1'b0);
        ramp_frame(1'b0);
        f1 = 0; f2 = 0; f2_early = 0;
        foreach (pulse_acc[i]) begin
            if (pulse_acc[i] <= 16) f1++;
            else f2++;
            if (pulse_acc[i] > 16 && pulse_acc[i] <= 24) f2_early++;
        end
        chk("wrap_frame1_pulses", 108'(f1), 108'(4));
        chk("wrap_frame2_pulses", 108'(f2), 108'(4));
        chk("wrap_frame2_early", 108'(f2_early), 108'(0));

`ifdef GAUSS_SOF_SYNC_EN
        // SOF with the 5th pixel restarts the frame; SOF without valid is ignored
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clr_stats();
        step(1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < W*H; i++) step(1'b1, 8'(16*(i/W) + (i%W)), 1'b0, 1'b0);
        chk("sof_first_acc", 108'(first_acc), 108'(11));
        chk("sof_pulses", 108'(pulse_cnt), 108'(4));
        chk_first_ramp("sof");
`endif

        // Random traffic with occasional resets, checked by the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic r, v;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 7);
            step(v, 8'($urandom), 1'b0, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gauss_window_gen
`default_nettype wire
